// File: rtl/redun_mont_pkg.sv
// rtl/redun_mont_pkg.sv - shared word-vector, iteration and sequencer state types
package redun_mont_pkg;
  localparam int NUM_WRDS      = 4;
  localparam int WRD_BITS      = 16;
  localparam int ITER_BITS_DEF = 64;

  // Each word carries one extra carry bit in redundant form.
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
  typedef logic [ITER_BITS_DEF-1:0]        iter_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;
endpackage

// File: rtl/redun_mont_seq_if.sv
// rtl/redun_mont_seq_if.sv - host-side start/result/checkpoint bundle of the sequencer
interface redun_mont_seq_if
  import redun_mont_pkg::*;
#(
  parameter int ITER_BITS = ITER_BITS_DEF
) ();
  redun0_t              i_sq;
  logic [ITER_BITS-1:0] i_iters;
  logic                 i_val;
  logic                 o_rdy;
  logic                 i_abort;
  redun0_t              o_res;
  logic                 o_val;
  logic                 i_rdy;
  logic                 o_err;
  redun0_t              o_chk;
  logic [ITER_BITS-1:0] o_chk_iter;
  logic                 o_chk_val;

  modport master (
    output i_sq, i_iters, i_val, i_abort, i_rdy,
    input  o_rdy, o_res, o_val, o_err, o_chk, o_chk_iter, o_chk_val
  );

  modport slave (
    input  i_sq, i_iters, i_val, i_abort, i_rdy,
    output o_rdy, o_res, o_val, o_err, o_chk, o_chk_iter, o_chk_val
  );
endinterface

// File: rtl/redun_mont_wdog.sv
// rtl/redun_mont_wdog.sv - loadable down-counter flagging the last cycle of its window
module redun_mont_wdog #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Asserted on the edge that would take the count to zero.
  assign expire = (cnt == W'(1));
endmodule

// File: rtl/redun_mont_seq.sv
// rtl/redun_mont_seq.sv - runs the squaring core exactly T times and returns the result
module redun_mont_seq
  import redun_mont_pkg::*;
#(
  parameter int ITER_BITS    = ITER_BITS_DEF,
  parameter int CHK_INTERVAL = 1024,
  parameter int WDOG_CYCLES  = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  redun_mont_seq_if.slave host,
  output logic            o_core_rst,
  output redun0_t         o_core_sq,
  output logic            o_core_val,
  input  redun0_t         i_core_mul,
  input  logic            i_core_val
);
  localparam int               CHK_W    = (CHK_INTERVAL > 1) ? $clog2(CHK_INTERVAL) : 1;
  localparam logic [CHK_W-1:0] CHK_LAST = (CHK_INTERVAL > 0) ? CHK_W'(CHK_INTERVAL - 1) : '0;
  localparam bit               CHK_EN   = (CHK_INTERVAL != 0);

  seq_state_t           state;
  logic [ITER_BITS-1:0] cnt;
  logic [ITER_BITS-1:0] cnt_nxt;
  logic [ITER_BITS-1:0] iters;
  logic [CHK_W-1:0]     chk_cnt;
  logic                 chk_hit;
  logic                 accept;
  logic                 wdog_load;
  logic                 wdog_expire;

  assign accept    = host.i_val && host.o_rdy;
  assign cnt_nxt   = cnt + ITER_BITS'(1);
  assign chk_hit   = CHK_EN && (chk_cnt == CHK_LAST);
  assign wdog_load = (state == LOAD) || (state == RUN && i_core_val);

  redun_mont_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (wdog_load),
    .dec    (state == RUN),
    .expire (wdog_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      iters           <= '0;
      chk_cnt         <= '0;
      host.o_rdy      <= 1'b0;
      host.o_res      <= '0;
      host.o_val      <= 1'b0;
      host.o_err      <= 1'b0;
      host.o_chk      <= '0;
      host.o_chk_iter <= '0;
      host.o_chk_val  <= 1'b0;
      o_core_rst      <= 1'b1;
      o_core_sq       <= '0;
      o_core_val      <= 1'b0;
    end else begin
      host.o_chk_val <= 1'b0;
      o_core_val     <= 1'b0;
      case (state)
        IDLE: begin
          host.o_rdy <= 1'b1;
          o_core_rst <= 1'b1;
          if (accept) begin
            host.o_rdy <= 1'b0;
            host.o_err <= 1'b0;
            iters      <= host.i_iters;
            cnt        <= '0;
            chk_cnt    <= '0;
            if (host.i_iters == '0) begin
              // Zero squarings: the input is already the answer.
              host.o_res <= host.i_sq;
              host.o_val <= 1'b1;
              state      <= DONE;
            end else begin
              o_core_sq  <= host.i_sq;
              o_core_rst <= 1'b0;
              o_core_val <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (host.i_abort) begin
            o_core_rst <= 1'b1;
            host.o_rdy <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (host.i_abort) begin
            o_core_rst <= 1'b1;
            host.o_rdy <= 1'b1;
            state      <= IDLE;
          end else if (i_core_val) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == iters) begin
              host.o_res <= i_core_mul;
              host.o_val <= 1'b1;
              o_core_rst <= 1'b1;
              state      <= DONE;
            end
            if (chk_hit) begin
              host.o_chk      <= i_core_mul;
              host.o_chk_iter <= cnt_nxt;
              host.o_chk_val  <= 1'b1;
              chk_cnt         <= '0;
            end else begin
              chk_cnt <= chk_cnt + CHK_W'(1);
            end
          end else if (wdog_expire) begin
            host.o_err <= 1'b1;
            host.o_rdy <= 1'b1;
            o_core_rst <= 1'b1;
            state      <= IDLE;
          end
        end
        DONE: begin
          if (host.i_rdy) begin
            host.o_val <= 1'b0;
            host.o_rdy <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_redun_mont_seq.sv
// tb/tb_redun_mont_seq.sv - randomized self-checking bench with a modular-squaring core stand-in
module tb_redun_mont_seq;
  import redun_mont_pkg::*;

  localparam int          WDOG = 64;
  localparam int          CHK  = 1024;
  localparam logic [63:0] P    = 64'h1FFF_FFFF_FFFF_FFFF;

  logic    clk;
  logic    rst;
  logic    core_rst;
  redun0_t core_sq;
  logic    core_start;
  redun0_t core_mul;
  logic    core_pulse;

  redun_mont_seq_if #(.ITER_BITS(64)) host ();

  redun_mont_seq #(
    .ITER_BITS    (64),
    .CHK_INTERVAL (CHK),
    .WDOG_CYCLES  (WDOG)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .host       (host),
    .o_core_rst (core_rst),
    .o_core_sq  (core_sq),
    .o_core_val (core_start),
    .i_core_mul (core_mul),
    .i_core_val (core_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // core stand-in state
  logic [63:0] cur;
  logic [67:0] flat;
  bit          run = 0;
  int          gap = 0;
  int          pulses = 0;
  int          last_edge = 0;
  bit          stall_en = 0;
  int          stall_after = 0;
  bit          core_start_seen = 0;

  int          chk_iters[$];
  logic [63:0] chk_vals[$];

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'h0, a} * {64'h0, b};
    return 64'(p % {64'h0, P});
  endfunction

  // x^(2^t) mod P
  function automatic logic [63:0] sq_model(input logic [63:0] x, input int t);
    logic [63:0] v;
    v = x;
    for (int i = 0; i < t; i++) v = mulmod(v, v);
    return v;
  endfunction

  function automatic logic [63:0] rand_val();
    return {$urandom, $urandom} & 64'h0FFF_FFFF_FFFF_FFFF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core stand-in: squares mod P once per pulse, pulses with random gaps after a start.
  initial begin
    core_pulse = 1'b0;
    core_mul   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || core_rst) begin
        run        = 0;
        core_pulse = 1'b0;
      end else if (core_start) begin
        core_start_seen = 1;
        flat       = core_sq;
        cur        = flat[63:0];
        run        = 1;
        pulses     = 0;
        gap        = $urandom_range(0, 2);
        core_pulse = 1'b0;
      end else if (run && !(stall_en && pulses >= stall_after)) begin
        if (gap == 0) begin
          cur        = mulmod(cur, cur);
          core_mul   = redun0_t'({4'h0, cur});
          core_pulse = 1'b1;
          pulses++;
          last_edge  = cyc + 1;
          gap        = $urandom_range(0, 2);
        end else begin
          core_pulse = 1'b0;
          gap--;
        end
      end else begin
        core_pulse = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (host.o_chk_val === 1'b1) begin
      flat = host.o_chk;
      chk_iters.push_back(int'(host.o_chk_iter));
      chk_vals.push_back(flat[63:0]);
    end
  end

  task automatic do_start(input logic [63:0] x, input iter_t t);
    int n = 0;
    host.i_sq    = redun0_t'({4'h0, x});
    host.i_iters = t;
    host.i_val   = 1'b1;
    while (host.o_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (host.o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL start_rdy: o_rdy=%b required 1", host.o_rdy);
    end
    @(negedge clk);
    host.i_val = 1'b0;
  endtask

  task automatic wait_val(input int budget, output bit ok);
    int n = 0;
    while (host.o_val !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (host.o_val === 1'b1);
  endtask

  task automatic finish_job(input string name, input logic [63:0] exp);
    bit ok;
    logic [67:0] exp68;
    exp68 = {4'h0, exp};
    wait_val(20000, ok);
    checks++;
    if (!ok || host.o_res !== exp68) begin
      errors++;
      $display("FAIL %s_res: o_val=%b o_res=%h required %h", name, host.o_val, host.o_res, exp68);
    end
    host.i_rdy = 1'b1;
    @(negedge clk);
    host.i_rdy = 1'b0;
    checks++;
    if (host.o_val !== 1'b0 || host.o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: o_val=%b o_rdy=%b required 0/1", name, host.o_val, host.o_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (host.o_rdy !== 1'b0 || host.o_val !== 1'b0 || host.o_err !== 1'b0 ||
        host.o_chk_val !== 1'b0 || core_start !== 1'b0 || core_rst !== 1'b1 || host.o_res !== '0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b val=%b err=%b chk_val=%b core_val=%b core_rst=%b res=%h required 0/0/0/0/0/1/0",
               host.o_rdy, host.o_val, host.o_err, host.o_chk_val, core_start, core_rst, host.o_res);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (host.o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: o_rdy=%b required 1", host.o_rdy);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_start(64'd3, 64'd1);
    checks++;
    if (core_start !== 1'b1 || core_rst !== 1'b0 || core_sq !== redun0_t'(68'd3) || host.o_rdy !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: core_val=%b core_rst=%b core_sq=%h rdy=%b required 1/0/3/0",
               core_start, core_rst, core_sq, host.o_rdy);
    end
    wait_val(200, ok);
    checks++;
    if (!ok || cyc != last_edge) begin
      errors++;
      $display("FAIL single_latency: o_val=%b at edge %0d required edge %0d", host.o_val, cyc, last_edge);
    end
    finish_job("single", 64'd9);
  endtask

  task automatic test_long();
    bit ok;
    bit hold_ok = 1;
    logic [63:0] x, v;
    logic [63:0] exp_chk[4];
    logic [67:0] res0;
    x = rand_val();
    v = x;
    for (int r = 1; r <= 5000; r++) begin
      v = mulmod(v, v);
      if (r % CHK == 0 && r / CHK <= 4) exp_chk[r / CHK - 1] = v;
    end
    chk_iters.delete();
    chk_vals.delete();
    do_start(x, 64'd5000);
    wait_val(30000, ok);
    checks++;
    if (chk_iters.size() != 4) begin
      errors++;
      $display("FAIL chk_count: %0d checkpoints required 4", chk_iters.size());
    end
    for (int i = 0; i < 4 && i < chk_iters.size(); i++) begin
      checks++;
      if (chk_iters[i] != CHK * (i + 1) || chk_vals[i] !== exp_chk[i]) begin
        errors++;
        $display("FAIL chk_%0d: iter=%0d val=%h required iter=%0d val=%h",
                 i, chk_iters[i], chk_vals[i], CHK * (i + 1), exp_chk[i]);
      end
    end
    res0 = host.o_res;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host.o_val !== 1'b1 || host.o_res !== res0) hold_ok = 0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL long_hold: o_val=%b res=%h required 1/%h", host.o_val, host.o_res, res0);
    end
    finish_job("long", v);
  endtask

  task automatic test_zero();
    logic [63:0] x;
    x = rand_val();
    core_start_seen = 0;
    do_start(x, 64'd0);
    checks++;
    if (host.o_val !== 1'b1 || host.o_res !== redun0_t'({4'h0, x}) || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL zero_result: val=%b res=%h core_rst=%b required 1/%h/1", host.o_val, host.o_res, core_rst, x);
    end
    finish_job("zero", x);
    checks++;
    if (core_start_seen) begin
      errors++;
      $display("FAIL zero_core_start: core start seen=%b required 0", core_start_seen);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    bit val_seen = 0;
    logic [63:0] y;
    do_start(rand_val(), 64'd100);
    while (pulses < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    host.i_abort = 1'b1;
    @(negedge clk);
    host.i_abort = 1'b0;
    checks++;
    if (host.o_rdy !== 1'b1 || core_rst !== 1'b1 || host.o_val !== 1'b0 || pulses < 10) begin
      errors++;
      $display("FAIL abort_idle: rdy=%b core_rst=%b val=%b pulses=%0d required 1/1/0/>=10",
               host.o_rdy, core_rst, host.o_val, pulses);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (host.o_val === 1'b1) val_seen = 1;
    end
    checks++;
    if (val_seen) begin
      errors++;
      $display("FAIL abort_noval: o_val seen=%b required 0", val_seen);
    end
    y = rand_val();
    do_start(y, 64'd2);
    finish_job("after_abort", sq_model(y, 2));
  endtask

  task automatic test_wdog();
    int n = 0;
    logic [63:0] y;
    stall_en    = 1;
    stall_after = 3;
    do_start(rand_val(), 64'd50);
    while (host.o_err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (host.o_err !== 1'b1 || cyc - last_edge != WDOG) begin
      errors++;
      $display("FAIL wdog_timing: err=%b after %0d cycles required 1 after %0d", host.o_err, cyc - last_edge, WDOG);
    end
    checks++;
    if (host.o_rdy !== 1'b1 || host.o_val !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL wdog_idle: rdy=%b val=%b core_rst=%b required 1/0/1", host.o_rdy, host.o_val, core_rst);
    end
    stall_en = 0;
    y = rand_val();
    do_start(y, 64'd0);
    checks++;
    if (host.o_err !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear: o_err=%b required 0", host.o_err);
    end
    finish_job("after_wdog", y);
  endtask

  task automatic test_rst_mid();
    int n = 0;
    logic [63:0] y;
    do_start(rand_val(), 64'd100);
    while (pulses < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (host.o_rdy !== 1'b0 || host.o_val !== 1'b0 || host.o_err !== 1'b0 || host.o_chk_val !== 1'b0 ||
        core_start !== 1'b0 || core_rst !== 1'b1 || host.o_res !== '0 || core_sq !== '0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b val=%b err=%b core_val=%b core_rst=%b res=%h required reset values",
               host.o_rdy, host.o_val, host.o_err, core_start, core_rst, host.o_res);
    end
    rst = 1'b0;
    @(negedge clk);
    y = rand_val();
    do_start(y, 64'd3);
    finish_job("after_rst", sq_model(y, 3));
  endtask

  initial begin
    rst          = 1'b1;
    host.i_sq    = '0;
    host.i_iters = '0;
    host.i_val   = 1'b0;
    host.i_abort = 1'b0;
    host.i_rdy   = 1'b0;
    test_reset();
    test_single();
    test_long();
    test_zero();
    test_abort();
    test_wdog();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/redun_mont_seq.md
# redun_mont_seq

Iteration sequencer for the redundant-form Montgomery squaring core. Accepts a start request (initial value plus iteration count T), launches the free-running squaring core, counts its per-square result pulses, and returns the value after exactly T squarings over a valid/ready handshake. Also emits periodic checkpoints, supports abort, and runs a watchdog on the core's result cadence. Sits between the host/AXI control shell and a single squaring core instance.

## Interface
- NUM_WRDS, WRD_BITS: from redun_mont_pkg; word vector is NUM_WRDS × [WRD_BITS:0].
- ITER_BITS, 64: width of the iteration count.
- CHK_INTERVAL, 1024: checkpoint period in squarings; 0 disables checkpoints.
- WDOG_CYCLES, 64: maximum cycles allowed between core result pulses while running.
- i_clk  in  1  clock.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_sq  in  NUM_WRDS×(WRD_BITS+1)  initial value, redundant form.
- i_iters  in  ITER_BITS  squaring count T.
- i_val / o_rdy  in / out  1  start handshake; accept on i_val & o_rdy.
- i_abort  in  1  cancel the current run.
- o_res  out  NUM_WRDS×(WRD_BITS+1)  final value.
- o_val / i_rdy  out / in  1  result handshake.
- o_err  out  1  sticky watchdog error; cleared on the next accepted start.
- o_chk, o_chk_iter, o_chk_val  out  words / ITER_BITS / 1  checkpoint value, its iteration number, and a one-cycle strobe (no backpressure).
- o_core_rst, o_core_sq, o_core_val  out  1 / words / 1  core reset, core input value, core start pulse.
- i_core_mul, i_core_val  in  words / 1  core result and per-square strobe.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: o_rdy=1 and o_core_rst=1. On accept, latch i_sq and i_iters, clear cnt, clear o_err.
  - If i_iters==0: set o_res=i_sq and go to DONE; the core is never started.
  - Otherwise go to LOAD.
- LOAD (one cycle): o_core_rst=0, o_core_val=1, o_core_sq=latched value. Go to RUN.
- RUN: o_core_rst=0. On each i_core_val:
  - cnt←cnt+1; watchdog counter cleared.
  - If cnt+1 == T: o_res←i_core_mul, go to DONE.
  - If CHK_INTERVAL≠0 and (cnt+1) mod CHK_INTERVAL == 0: o_chk←i_core_mul, o_chk_iter←cnt+1, o_chk_val pulses next cycle. This also fires when it coincides with completion.
- DONE: o_val=1 and o_core_rst=1, holding o_res until i_rdy. Then go to IDLE.
- Watchdog: in RUN, if WDOG_CYCLES cycles pass without i_core_val: set o_err=1 and go to IDLE; no result is produced.
- i_abort in LOAD or RUN: go to IDLE next cycle with o_core_rst=1; no result, o_err unchanged. i_abort in IDLE or DONE is ignored.
- i_core_val seen outside RUN is ignored.
- Counting uses full ITER_BITS width with no wrap; T=2^ITER_BITS−1 is legal.

## Timing
- All outputs are registered.
- Reset values: o_rdy=0 during reset and 1 on the first cycle after; o_val=0, o_err=0, o_chk_val=0, o_core_val=0, o_core_rst=1, all data outputs 0, state IDLE.
- Accept at edge k → LOAD during cycle k+1 (o_core_val high) → RUN from k+2.
- o_val rises the cycle after the T-th i_core_val.
- T=0: o_val rises the cycle after accept.
- o_rdy=0 in LOAD, RUN and DONE. Back-to-back: after the o_val&i_rdy edge, IDLE with o_rdy=1 the following cycle.
- o_core_rst deasserts in the same cycle as o_core_val; the core samples both on one edge.
- Reset mid-run: everything returns to reset values next cycle and the core is held in reset.

## Structure
- Word-vector type (redun0_t) and NUM_WRDS/WRD_BITS come from redun_mont_pkg.
- Add an iteration-count typedef to the package.
- Instantiates nothing; the core is a sibling in the top level.
- A natural sub-module is redun_mont_wdog (loadable down-counter with expire flag).
- Target size 150–250 lines.

## Test plan
- Each scenario runs against the real core with a model of (x^(2^T)) mod P that converts from redundant form.
- T=1, i_sq=to_redun(3): one core pulse → o_val the next cycle; o_res matches 9·R⁻¹ mod P.
- T=5000, CHK_INTERVAL=1024: o_chk_val pulses at iterations 1024, 2048, 3072 and 4096. Final o_res matches the model; o_val held under 20 cycles of i_rdy=0.
- T=0, i_sq=X: o_res=X one cycle after accept; o_core_val never asserts and o_core_rst stays high.
- Abort at iteration 10 of T=100: o_val never rises; IDLE with o_rdy=1 the next cycle. A following T=2 run is correct.
- Core stalled (i_core_val forced low after 3 pulses): o_err=1 exactly WDOG_CYCLES cycles after the last pulse, then IDLE. The next accepted start clears o_err.
- i_rst asserted during RUN: all outputs at reset values on the next cycle and o_core_rst=1; a fresh T=3 run completes correctly.
